// File: rtl/transpose_collector.sv
// Serial-in/parallel-out collector: DEPTH words, lane 0 first, into a held valid/ready vector.
// Optional COLLECT_FLUSH_EN adds a flush input that zero-pads and closes a partial vector.
module transpose_collector #(
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [BITS-1:0]          in_data,
  input  logic                     stall,
`ifdef COLLECT_FLUSH_EN
  input  logic                     flush,
`endif
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DEPTH*BITS-1:0]    q,
  output logic [$clog2(DEPTH)-1:0] level
);

  localparam int CW = $clog2(DEPTH);

  typedef enum logic {FILL, PEND} state_t;

  state_t          state, state_nxt;
  logic [BITS-1:0] acc [DEPTH];
  logic [BITS-1:0] vec [DEPTH];
  logic [CW-1:0]   cnt;
  logic            accept, pop, last, complete, flush_req;

  always_comb begin
`ifdef COLLECT_FLUSH_EN
    flush_req = flush;
`else
    flush_req = 1'b0;
`endif
    in_ready = (state == FILL) && !stall;
    accept   = in_valid && in_ready;
    pop      = out_valid && out_ready;
    last     = accept && (cnt == CW'(DEPTH-1));
    complete = (state == FILL) && (last || (flush_req && (accept || cnt != '0)));
    level    = (state == PEND) ? CW'(DEPTH-1) : cnt;
  end

  // Candidate vector: held lanes, then the word arriving this cycle, zeros above.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vec[i] = '0;
      if (CW'(i) < cnt)
        vec[i] = acc[i];
      else if (CW'(i) == cnt && accept)
        vec[i] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= FILL;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (complete && out_valid && !pop) state_nxt = PEND;
      PEND: if (pop) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      q         <= '0;
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else if (state == PEND) begin
      if (pop) begin
        for (int i = 0; i < DEPTH; i++) q[i*BITS +: BITS] <= acc[i];
        out_valid <= 1'b1;
        cnt       <= '0;
      end
    end else if (complete) begin
      if (!out_valid || pop) begin
        for (int i = 0; i < DEPTH; i++) q[i*BITS +: BITS] <= vec[i];
        out_valid <= 1'b1;
        cnt       <= '0;
      end else begin
        // Output still occupied: park the finished vector in acc until the next pop.
        for (int i = 0; i < DEPTH; i++) acc[i] <= vec[i];
      end
    end else begin
      if (accept) begin
        acc[cnt] <= in_data;
        cnt      <= cnt + CW'(1);
      end
      if (pop) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_transpose_collector.sv
// Directed self-checking bench for transpose_collector (DEPTH=8, BITS=8).
module tb_transpose_collector;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, stall, out_ready, in_ready, out_valid;
  logic [7:0]  in_data;
  logic [63:0] q;
  logic [2:0]  level;
`ifdef COLLECT_FLUSH_EN
  logic        flush;
`endif

  int passed = 0;
  int total  = 0;

  transpose_collector #(.DEPTH(8), .BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .stall(stall),
`ifdef COLLECT_FLUSH_EN
    .flush(flush),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .q(q), .level(level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed one word on the next edge (inputs change #1 after an edge).
  task automatic feed(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] ramp(input int base);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(base + i);
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; stall = 1'b0; out_ready = 1'b0;
`ifdef COLLECT_FLUSH_EN
    flush = 1'b0;
`endif
    step(); step();
    rst_n = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
    total++; if (q !== 64'h0) $display("FAIL reset_q got %h want 0", q); else passed++;
    total++; if (level !== 3'd0) $display("FAIL reset_level got %0d want 0", level); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passed++;
  endtask

  task automatic test_single_vector();
    logic rdy_ok = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      if (in_ready !== 1'b1) rdy_ok = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL single_early_valid word %0d got %0b want 0", i, out_valid); else passed++;
      step();
    end
    in_valid = 1'b0;
    total++; if (rdy_ok !== 1'b1) $display("FAIL single_in_ready got dropped want always 1"); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got %0b want 1", out_valid); else passed++;
    total++; if (q !== ramp(1)) $display("FAIL single_q got %h want %h", q, ramp(1)); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL single_drain got %0b want 0", out_valid); else passed++;
  endtask

  task automatic test_pend();
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) feed(8'(i));
    total++; if (q !== ramp(1)) $display("FAIL pend_q_held got %h want %h", q, ramp(1)); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL pend_in_ready got %0b want 0", in_ready); else passed++;
    total++; if (level !== 3'd7) $display("FAIL pend_level got %0d want 7", level); else passed++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    total++; if (q !== ramp(9)) $display("FAIL pend_q_next got %h want %h", q, ramp(9)); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL pend_out_valid got %0b want 1", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL pend_in_ready_back got %0b want 1", in_ready); else passed++;
    total++; if (level !== 3'd0) $display("FAIL pend_level_back got %0d want 0", level); else passed++;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL pend_drain got %0b want 0", out_valid); else passed++;
  endtask

  task automatic test_stall();
    logic [63:0] exp;
    out_ready = 1'b1;
    feed(8'd10); feed(8'd11); feed(8'd12);
    in_valid = 1'b1; in_data = 8'd99; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready cycle %0d got %0b want 0", c, in_ready); else passed++;
      total++; if (level !== 3'd3) $display("FAIL stall_level cycle %0d got %0d want 3", c, level); else passed++;
      step();
    end
    in_valid = 1'b0; stall = 1'b0;
    for (int i = 13; i <= 17; i++) feed(8'(i));
    exp = ramp(10);
    total++; if (q[31:24] !== 8'd13) $display("FAIL stall_lane3 got %0d want 13", q[31:24]); else passed++;
    total++; if (q !== exp) $display("FAIL stall_q got %h want %h", q, exp); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    logic rdy_ok = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(40 + i);
      #1;
      if (in_ready !== 1'b1) rdy_ok = 1'b0;
      if (i == 8) begin
        total++; if (q !== ramp(40) || out_valid !== 1'b1)
          $display("FAIL b2b_first got %h/%0b want %h/1", q, out_valid, ramp(40)); else passed++;
      end
      step();
    end
    in_valid = 1'b0;
    total++; if (rdy_ok !== 1'b1) $display("FAIL b2b_in_ready got bubble want none"); else passed++;
    total++; if (q !== ramp(48) || out_valid !== 1'b1)
      $display("FAIL b2b_second got %h/%0b want %h/1", q, out_valid, ramp(48)); else passed++;
    step();
  endtask

`ifdef COLLECT_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b1;
    feed(8'd5); feed(8'd6); feed(8'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (q !== 64'h0000_0000_0007_0605) $display("FAIL flush_q got %h want 0000000000070605", q); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL flush_out_valid got %0b want 1", out_valid); else passed++;
    total++; if (level !== 3'd0) $display("FAIL flush_level got %0d want 0", level); else passed++;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_empty got %0b want 0", out_valid); else passed++;
  endtask
`endif

  task automatic test_mid_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(8'(70 + i));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    total++; if (level !== 3'd0) $display("FAIL mreset_level got %0d want 0", level); else passed++;
    for (int i = 20; i <= 27; i++) begin
      total++; if (out_valid !== 1'b0) $display("FAIL mreset_early_valid before %0d got %0b want 0", i, out_valid); else passed++;
      feed(8'(i));
    end
    total++; if (out_valid !== 1'b1) $display("FAIL mreset_out_valid got %0b want 1", out_valid); else passed++;
    total++; if (q !== ramp(20)) $display("FAIL mreset_q got %h want %h", q, ramp(20)); else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_single_vector();
    test_pend();
    test_stall();
    test_back_to_back();
`ifdef COLLECT_FLUSH_EN
    test_flush();
`endif
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
